// File: rtl/if_pkg.sv
// Shared types and default parameters for the instr_fetch_q fetch stage.
package if_pkg;

  localparam int              DEF_AW       = 8;
  localparam int              DEF_IW       = 32;
  localparam int              DEF_DEPTH    = 4;
  localparam logic [DEF_AW-1:0] DEF_RESET_PC = '0;

  // Layout of one prefetch slot at the default widths.
  typedef struct packed {
    logic [DEF_IW-1:0] instr;
    logic [DEF_AW-1:0] pc;
  } if_entry_t;

  // Width of an occupancy counter that must reach `depth` inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous prefetch FIFO with flush; flush and reset outrank push.
module if_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = DEF_DEPTH,
  parameter type entry_t = if_entry_t,
  localparam int CW      = count_width(DEPTH)
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output entry_t        head
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (do_pop || (count != CW'(DEPTH)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates every read,
  // so stale slots are never observed and the array maps onto plain RAM/regs.
  always_ff @(posedge clk1) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_q.sv
// Decoupled instruction-fetch stage: PC, 1-cycle imem requests, prefetch FIFO.
// Optional: define IF_STALL_CNT_EN to add the 16-bit saturating stall_cnt output.
module instr_fetch_q
  import if_pkg::*;
#(
  parameter int            AW       = DEF_AW,
  parameter int            IW       = DEF_IW,
  parameter int            DEPTH    = DEF_DEPTH,
  parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC),
  parameter int            PC_STEP  = 1
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output logic [AW-1:0] out_npc
`ifdef IF_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  localparam int            CW   = count_width(DEPTH);
  localparam logic [AW-1:0] STEP = AW'(PC_STEP);

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] req_pc;
  logic          rsp_pending;
  logic [CW-1:0] count;
  entry_t        push_data;
  entry_t        head;
  logic          pop;

  // Counting in-flight responses as occupied keeps the FIFO from ever
  // overflowing, at the cost of one idle slot when decode pops same-cycle.
  assign imem_req  = !rst && !redirect &&
                     ((int'(count) + int'(rsp_pending)) < DEPTH);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk1) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pending <= 1'b0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc;
      rsp_pending <= 1'b0;
    end else begin
      rsp_pending <= imem_req;
      if (imem_req) fetch_pc <= fetch_pc + STEP;
    end
  end

  // PC of the request whose data returns next cycle.
  always_ff @(posedge clk1) begin
    if (imem_req) req_pc <= fetch_pc;
  end

  assign push_data.instr = imem_rdata;
  assign push_data.pc    = req_pc;
  assign pop             = out_valid && out_ready;

  if_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk1      (clk1),
    .rst       (rst),
    .flush     (redirect),
    .push      (rsp_pending && !redirect),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign out_npc   = head.pc + STEP;

`ifdef IF_STALL_CNT_EN
  // Back-pressure cycles; survives redirects, saturates instead of wrapping.
  always_ff @(posedge clk1) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
